// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: op encodings, funct codes and FSM states.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    // The low two funct bits double as the op encoding for the muldiv unit.
    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_isDiv,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;

    // The divide remainder never exceeds 2*divisor-1, so bit WIDTH of the difference is a clean borrow.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_rem  = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_rem - {1'b0, i_operand};
        if (!i_isDiv) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [1:0]       mt_i,
    input  logic [WIDTH-1:0] mtdata_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_isDiv;
    logic               r_negLow;
    logic               r_negHigh;
    logic               r_done;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_isDivOp;
    logic               w_signed;
    logic               w_divZero;
    logic [WIDTH-1:0]   w_rsMag;
    logic [WIDTH-1:0]   w_rtMag;
    logic [2*WIDTH-1:0] w_stepAcc;
    logic [2*WIDTH-1:0] w_fixAcc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_isDiv   (r_isDiv),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_stepAcc)
    );

    // Divide-by-zero keeps the raw dividend so the remainder comes out as the original rs bits.
    always_comb begin
        w_isDivOp = (op_i == OP_DIV) || (op_i == OP_DIVU);
        w_signed  = (op_i == OP_MULT) || (op_i == OP_DIV);
        w_divZero = w_isDivOp && (rt_i == '0);
        w_rsMag   = (w_signed && rs_i[WIDTH-1] && !w_divZero) ? -rs_i : rs_i;
        w_rtMag   = (w_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;

        w_fixAcc = r_acc;
        if (!r_isDiv) begin
            if (r_negLow) w_fixAcc = -r_acc;
        end else begin
            if (r_negLow)  w_fixAcc[WIDTH-1:0]       = -r_acc[WIDTH-1:0];
            if (r_negHigh) w_fixAcc[2*WIDTH-1:WIDTH] = -r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_negLow  <= 1'b0;
            r_negHigh <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mt_i[1]) r_hi <= mtdata_i;
                    if (mt_i[0]) r_lo <= mtdata_i;
                    if (start_i && !flush_i) begin
                        r_isDiv   <= w_isDivOp;
                        r_negLow  <= w_signed && !w_divZero && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                        r_negHigh <= w_signed && !w_divZero && w_isDivOp && rs_i[WIDTH-1];
                        r_acc     <= {{WIDTH{1'b0}}, (w_isDivOp ? w_rsMag : w_rtMag)};
                        r_operand <= w_isDivOp ? w_rtMag : w_rsMag;
                        r_cnt     <= '0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= w_stepAcc;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!flush_i) begin
                        r_hi   <= w_fixAcc[2*WIDTH-1:WIDTH];
                        r_lo   <= w_fixAcc[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the rs/rt operand data and the decoded mult/div operation latched by ID/EX. It also owns the architectural HI/LO registers read by MFHI/MFLO. While an operation is in flight it raises a stall request to the hazard logic, which freezes PC, IF/ID and ID/EX.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  ID/EX holds a MULT/MULTU/DIV/DIVU; sampled only in IDLE
op_i  in  2  operation, equal to funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_i  in  WIDTH  rsdata from ID/EX (multiplicand / dividend)
rt_i  in  WIDTH  rtdata from ID/EX (multiplier / divisor)
mt_i  in  2  bit1 = MTHI, bit0 = MTLO write request
mtdata_i  in  WIDTH  data for MTHI/MTLO
flush_i  in  1  abort the in-flight operation (branch/exception flush)
busy_o  out  1  stall request; high while state != IDLE
done_o  out  1  one-cycle pulse; HI/LO were updated at that edge
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset (rst_i=1 at an edge, any state): state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, busy_o=0. rst_i has priority over every other input.
- FSM states: IDLE, CALC, FIX.
- IDLE, start_i=1 at edge N:
  - latch op, sign flags and |rs|, |rt| (absolute values only for signed ops; unsigned ops take raw values);
  - latch a div-by-zero flag (DIV/DIVU with rt_i==0);
  - counter=0; go to CALC.
- CALC: one radix-2 step per edge.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Quotient builds in the low half, remainder in the high half.
  - After WIDTH steps (edge N+WIDTH) go to FIX.
- FIX, edge N+WIDTH+1:
  - apply sign correction. MULT negates the 64-bit product if signs differ. DIV negates the quotient if signs differ; the remainder takes the dividend's sign.
  - write HI/LO, done_o=1 for that one cycle, return to IDLE.
- Latency: start at edge N gives new HI/LO visible after edge N+WIDTH+1 (33 cycles for WIDTH=32).
- busy_o is high in CALC and FIX only. It is low in the cycle start_i is first presented; hazard logic must stall MFHI/MFLO/mult/div while busy_o=1.
- Result mapping:
  - multiply: HI = product[2W-1:W], LO = product[W-1:0];
  - divide: LO = quotient, HI = remainder.
- Divide by zero: LO=all ones, HI=rs_i (original, unsigned bits). Normal latency, no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Must fall out naturally from the abs/negate datapath.
- flush_i=1 in CALC/FIX: return to IDLE next edge. HI/LO unchanged, no done_o. flush_i in IDLE has no effect and blocks a same-cycle start_i.
- start_i while busy: ignored.
- mt_i: applied only in IDLE, at the edge, bitwise independent (both bits may be set). If start_i and mt_i coincide, the mt write occurs now and the muldiv result overwrites later. mt_i outside IDLE: ignored.
- hi_o/lo_o change only on reset, mt write, or FIX edge.

Decomposition:
- Shared package (mips_pkg):
  - localparams for op encoding: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - FSM state encoding;
  - funct codes 6'h18–6'h1B for the decoder.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-or-skip / trial-subtract). The FSM, counter, sign logic and HI/LO stay in ex_muldiv.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, done_o one pulse, busy_o high 32+1 cycles.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=7 rt=0 -> LO=0xFFFFFFFF, HI=0x00000007 at normal latency.
- MTHI 0x12345678 in IDLE, then MULT 3*4 -> HI=0x12345678 until FIX edge, then HI=0, LO=0x0000000C.
- Flush at cycle 10 of a DIV -> IDLE next edge, HI/LO unchanged, no done_o. rst_i at cycle 20 of a MULT -> IDLE, HI=LO=0, busy_o=0.
